// File: rtl/keycode_filter.sv
// keycode_filter: frame-rate conditioner for the USB keycode PIO.
// Resyncs, keeps only W/S/A/D, and commits a key after a stable run.
module keycode_filter #(
  parameter int STABLE_FRAMES  = 2,
  parameter int RELEASE_FRAMES = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode_raw,
  output logic [15:0] key_out,
  output logic [3:0]  dir,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [7:0]  hold_frames
);

  localparam logic [15:0] KEY_W = 16'h001A;
  localparam logic [15:0] KEY_S = 16'h0016;
  localparam logic [15:0] KEY_A = 16'h0004;
  localparam logic [15:0] KEY_D = 16'h0007;

  localparam logic [3:0] STB_THR = 4'(STABLE_FRAMES);
  localparam logic [3:0] REL_THR = 4'(RELEASE_FRAMES);

  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] n;
  logic [15:0] cand;
  logic [15:0] cand_next;
  logic [3:0]  run;
  logic [3:0]  run_next;
  logic [3:0]  thr;
  logic        commit;

  always_comb begin
    n = 16'h0000;
    unique case (1'b1)
      (s2 == KEY_W): n = KEY_W;
      (s2 == KEY_S): n = KEY_S;
      (s2 == KEY_A): n = KEY_A;
      (s2 == KEY_D): n = KEY_D;
      default:       n = 16'h0000;
    endcase
  end

  // Any skewed or non-movement sample breaks the run, so it never commits.
  always_comb begin
    cand_next = cand;
    run_next  = run;
    if (n == cand) begin
      run_next = (run == 4'hF) ? 4'hF : run + 4'd1;
    end else begin
      cand_next = n;
      run_next  = 4'd1;
    end
  end

  assign thr    = (cand_next != 16'h0000) ? STB_THR : REL_THR;
  assign commit = (run_next >= thr) && (cand_next != key_out);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      s1            <= 16'h0000;
      s2            <= 16'h0000;
      cand          <= 16'h0000;
      run           <= 4'd0;
      key_out       <= 16'h0000;
      hold_frames   <= 8'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1   <= keycode_raw;
      s2   <= s1;
      cand <= cand_next;
      run  <= run_next;
      if (commit) begin
        key_out       <= cand_next;
        hold_frames   <= 8'd0;
        press_pulse   <= (cand_next != 16'h0000);
        release_pulse <= (cand_next == 16'h0000);
      end else begin
        if (hold_frames != 8'hFF) begin
          hold_frames <= hold_frames + 8'd1;
        end
        press_pulse   <= 1'b0;
        release_pulse <= 1'b0;
      end
    end
  end

  always_comb begin
    dir = 4'b0000;
    unique case (1'b1)
      (key_out == KEY_W): dir = 4'b1000;
      (key_out == KEY_S): dir = 4'b0100;
      (key_out == KEY_A): dir = 4'b0010;
      (key_out == KEY_D): dir = 4'b0001;
      default:            dir = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_keycode_filter.sv
// tb_keycode_filter: scoreboard bench for keycode_filter.
// Stimulus pushes model expectations; a negedge monitor pops and compares.
module tb_keycode_filter;

  localparam int STB = 2;
  localparam int REL = 3;

  logic        frame_clk;
  logic        Reset;
  logic [15:0] keycode_raw;
  logic [15:0] key_out;
  logic [3:0]  dir;
  logic        press_pulse;
  logic        release_pulse;
  logic [7:0]  hold_frames;

  keycode_filter #(
    .STABLE_FRAMES (STB),
    .RELEASE_FRAMES(REL)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode_raw  (keycode_raw),
    .key_out      (key_out),
    .dir          (dir),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_frames  (hold_frames)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [15:0] key;
    logic [3:0]  dir;
    logic        pp;
    logic        rp;
    logic [7:0]  hold;
    int          frame;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: history of what the filter sees, in plain terms.
  logic [15:0] rawq[$];
  logic [15:0] hist[$];
  logic [15:0] mkey;
  int          ecount;
  int          lastc;

  function automatic logic [15:0] norm(input logic [15:0] v);
    if (v == 16'h001A || v == 16'h0016 || v == 16'h0004 || v == 16'h0007)
      return v;
    return 16'h0000;
  endfunction

  function automatic logic [3:0] dir_of(input logic [15:0] k);
    case (k)
      16'h001A: return 4'b1000;
      16'h0016: return 4'b0100;
      16'h0004: return 4'b0010;
      16'h0007: return 4'b0001;
      default:  return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    rawq   = '{16'h0000, 16'h0000};
    hist   = {};
    mkey   = 16'h0000;
    ecount = 0;
    lastc  = 0;
  endtask

  // One frame: the value seen now is the raw sample from two frames ago.
  task automatic model_edge(input logic [15:0] raw);
    exp_t        e;
    logic [15:0] v;
    int          runlen;
    int          thr;
    v = norm(rawq.pop_front());
    rawq.push_back(raw);
    hist.push_back(v);
    if (hist.size() > 16) void'(hist.pop_front());
    runlen = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != v || runlen == 15) break;
      runlen++;
    end
    ecount++;
    thr  = (v != 16'h0000) ? STB : REL;
    e.pp = 1'b0;
    e.rp = 1'b0;
    if (runlen >= thr && v != mkey) begin
      mkey  = v;
      lastc = ecount;
      e.pp  = (v != 16'h0000);
      e.rp  = (v == 16'h0000);
    end
    e.key   = mkey;
    e.dir   = dir_of(mkey);
    e.hold  = 8'((ecount - lastc) > 255 ? 255 : (ecount - lastc));
    e.frame = ecount;
    sb.push_back(e);
  endtask

  task automatic step(input logic [15:0] raw);
    keycode_raw = raw;
    @(posedge frame_clk);
    #1;
    model_edge(raw);
  endtask

  task automatic hold_key(input logic [15:0] raw, input int frames);
    for (int i = 0; i < frames; i++) step(raw);
  endtask

  always @(negedge frame_clk) begin
    if (!Reset && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (key_out !== e.key || dir !== e.dir || press_pulse !== e.pp ||
          release_pulse !== e.rp || hold_frames !== e.hold) begin
        n_bad++;
        $display("FAIL frame%0d got key=%h dir=%b pp=%b rp=%b hold=%0d want key=%h dir=%b pp=%b rp=%b hold=%0d",
                 e.frame, key_out, dir, press_pulse, release_pulse,
                 hold_frames, e.key, e.dir, e.pp, e.rp, e.hold);
      end
    end
  end

  task automatic check_zero(input string name);
    n_cmp++;
    if (key_out !== 16'h0000 || dir !== 4'b0000 || press_pulse !== 1'b0 ||
        release_pulse !== 1'b0 || hold_frames !== 8'd0) begin
      n_bad++;
      $display("FAIL %s got key=%h dir=%b pp=%b rp=%b hold=%0d want all zero",
               name, key_out, dir, press_pulse, release_pulse, hold_frames);
    end
  endtask

  logic [15:0] pool[8];

  initial begin
    pool = '{16'h001A, 16'h0016, 16'h0004, 16'h0007,
             16'h0000, 16'h0028, 16'h021A, 16'h0000};
    keycode_raw = 16'h0000;
    Reset = 1'b1;
    model_reset();
    #3;
    check_zero("reset_state");
    #4 Reset = 1'b0;

    hold_key(16'h0000, 3);
    hold_key(16'h001A, 8);
    hold_key(16'h0000, 6);
    hold_key(16'h0007, 300);
    hold_key(16'h0000, 6);
    hold_key(16'h0016, 6);
    hold_key(16'h0004, 6);
    hold_key(16'h001A, 6);
    hold_key(16'h0000, 2);
    hold_key(16'h001A, 4);
    hold_key(16'h0016, 1);
    hold_key(16'h001A, 4);
    hold_key(16'h0000, 6);
    hold_key(16'h0028, 10);
    hold_key(16'h021A, 10);
    hold_key(16'h0004, 20);

    @(negedge frame_clk);
    #1 Reset = 1'b1;
    #1 check_zero("mid_reset");
    model_reset();
    #1 Reset = 1'b0;
    hold_key(16'h0004, 8);

    for (int t = 0; t < 400; t++) begin
      logic [15:0] v;
      v = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) v = 16'($urandom);
      hold_key(v, $urandom_range(1, 6));
    end
    hold_key(16'h0000, 6);

    repeat (2) @(negedge frame_clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
